// File: rtl/board_button_seq.sv
// Walks a rows x cols button grid and issues one draw request per button over valid/ready.
// Define BOARD_SEQ_SERPENTINE_EN to traverse odd rows right to left.
module board_button_seq #(
  parameter int COORD_W = 11,
  parameter int SIZE_W  = 7,
  parameter int IDX_W   = 5,
  parameter int GAP_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] cfg_xpos,
  input  logic [COORD_W-1:0] cfg_ypos,
  input  logic [SIZE_W-1:0]  cfg_size,
  input  logic [GAP_W-1:0]   cfg_gap,
  input  logic [IDX_W-1:0]   cfg_cols,
  input  logic [IDX_W-1:0]   cfg_rows,
  input  logic               btn_ready,
  output logic               btn_valid,
  output logic [COORD_W-1:0] btn_xpos,
  output logic [COORD_W-1:0] btn_ypos,
  output logic [SIZE_W-1:0]  btn_size,
  output logic [IDX_W-1:0]   btn_col,
  output logic [IDX_W-1:0]   btn_row,
  output logic               busy,
  output logic               frame_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [COORD_W-1:0] x0;
  logic [SIZE_W:0]    pitch;
  logic [IDX_W-1:0]   cols;
  logic [IDX_W-1:0]   rows;
  logic [COORD_W-1:0] pitch_c;
  logic               row_end;
  logic               row_last;

  assign pitch_c  = COORD_W'(pitch);
  assign row_last = (btn_row == rows - IDX_W'(1));

  // The end of a row is the right edge, or the left edge on reversed rows.
`ifdef BOARD_SEQ_SERPENTINE_EN
  assign row_end = btn_row[0] ? (btn_col == '0) : (btn_col == cols - IDX_W'(1));
`else
  assign row_end = (btn_col == cols - IDX_W'(1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      btn_valid  <= 1'b0;
      btn_xpos   <= '0;
      btn_ypos   <= '0;
      btn_size   <= '0;
      btn_col    <= '0;
      btn_row    <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x0       <= cfg_xpos;
            pitch    <= {1'b0, cfg_size} + (SIZE_W+1)'(cfg_gap);
            cols     <= cfg_cols;
            rows     <= cfg_rows;
            busy     <= 1'b1;
            btn_xpos <= cfg_xpos;
            btn_ypos <= cfg_ypos;
            btn_size <= cfg_size;
            btn_col  <= '0;
            btn_row  <= '0;
            if (cfg_cols == '0 || cfg_rows == '0) begin
              state <= DONE;
            end else begin
              state     <= RUN;
              btn_valid <= 1'b1;
            end
          end
        end
        RUN: begin
          if (btn_ready) begin
            if (row_end) begin
              if (row_last) begin
                btn_valid <= 1'b0;
                state     <= DONE;
              end else begin
                btn_row  <= btn_row + IDX_W'(1);
                btn_ypos <= btn_ypos + pitch_c;
`ifndef BOARD_SEQ_SERPENTINE_EN
                btn_col  <= '0;
                btn_xpos <= x0;
`endif
              end
            end else begin
`ifdef BOARD_SEQ_SERPENTINE_EN
              if (btn_row[0]) begin
                btn_col  <= btn_col - IDX_W'(1);
                btn_xpos <= btn_xpos - pitch_c;
              end else begin
                btn_col  <= btn_col + IDX_W'(1);
                btn_xpos <= btn_xpos + pitch_c;
              end
`else
              btn_col  <= btn_col + IDX_W'(1);
              btn_xpos <= btn_xpos + pitch_c;
`endif
            end
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_button_seq.sv
// Scoreboard bench for board_button_seq: expected requests are queued at start, popped on accept.
`timescale 1ns/1ps
module tb_board_button_seq;
  localparam int COORD_W = 11;
  localparam int SIZE_W  = 7;
  localparam int IDX_W   = 5;
  localparam int GAP_W   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [COORD_W-1:0] cfg_xpos;
  logic [COORD_W-1:0] cfg_ypos;
  logic [SIZE_W-1:0]  cfg_size;
  logic [GAP_W-1:0]   cfg_gap;
  logic [IDX_W-1:0]   cfg_cols;
  logic [IDX_W-1:0]   cfg_rows;
  logic               btn_ready;
  logic               btn_valid;
  logic [COORD_W-1:0] btn_xpos;
  logic [COORD_W-1:0] btn_ypos;
  logic [SIZE_W-1:0]  btn_size;
  logic [IDX_W-1:0]   btn_col;
  logic [IDX_W-1:0]   btn_row;
  logic               busy;
  logic               frame_done;

  board_button_seq #(
    .COORD_W(COORD_W), .SIZE_W(SIZE_W), .IDX_W(IDX_W), .GAP_W(GAP_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_xpos(cfg_xpos), .cfg_ypos(cfg_ypos), .cfg_size(cfg_size), .cfg_gap(cfg_gap),
    .cfg_cols(cfg_cols), .cfg_rows(cfg_rows), .btn_ready(btn_ready),
    .btn_valid(btn_valid), .btn_xpos(btn_xpos), .btn_ypos(btn_ypos), .btn_size(btn_size),
    .btn_col(btn_col), .btn_row(btn_row), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [IDX_W-1:0]   col;
    logic [IDX_W-1:0]   row;
    logic [SIZE_W-1:0]  size;
  } req_t;

  req_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: every button of the frame, in traversal order.
  task automatic push_frame(input int x, input int y, input int s, input int g,
                            input int c, input int r);
    req_t e;
    int   pitch;
    int   col;
    pitch = s + g;
    for (int rr = 0; rr < r; rr++) begin
      for (int i = 0; i < c; i++) begin
        col = i;
`ifdef BOARD_SEQ_SERPENTINE_EN
        if (rr % 2 == 1) col = c - 1 - i;
`endif
        e.x    = COORD_W'(x + col * pitch);
        e.y    = COORD_W'(y + rr * pitch);
        e.col  = IDX_W'(col);
        e.row  = IDX_W'(rr);
        e.size = SIZE_W'(s);
        q.push_back(e);
      end
    end
  endtask

  task automatic start_frame(input int x, input int y, input int s, input int g,
                             input int c, input int r);
    cfg_xpos = COORD_W'(x);
    cfg_ypos = COORD_W'(y);
    cfg_size = SIZE_W'(s);
    cfg_gap  = GAP_W'(g);
    cfg_cols = IDX_W'(c);
    cfg_rows = IDX_W'(r);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // mode 0: ready held high, 1: ready 1-0-0-1, 2: ready high plus a stray start, 3: random ready
  task automatic run_frame(input int mode, input int exp_busy, input int exp_done_k);
    int done_k;
    int busy_cnt;
    done_k   = -1;
    busy_cnt = 0;
    for (int k = 0; k < 400 && done_k < 0; k++) begin
      case (mode)
        1:       btn_ready = (k % 4 == 0) || (k % 4 == 3);
        3:       btn_ready = 1'($urandom_range(0, 1));
        default: btn_ready = 1'b1;
      endcase
      if (mode == 2) begin
        start = (k == 2);
        if (k >= 2) cfg_cols = IDX_W'(1);
      end
      if (busy) busy_cnt++;
      if (frame_done) done_k = k;
      tick();
    end
    start     = 1'b0;
    btn_ready = 1'b0;
    if (done_k < 0) check_val("frame_done_timeout", 0, 1);
    if (exp_done_k >= 0) check_val("frame_done_latency", done_k, exp_done_k);
    if (exp_busy >= 0) check_val("busy_cycles", busy_cnt, exp_busy);
    check_val("done_pulse_width", frame_done, 0);
    check_val("busy_after_frame", busy, 0);
    check_val("queue_drained", q.size(), 0);
  endtask

  // Every valid cycle is compared against the head of the queue, so a held request must stay put.
  always @(negedge clk) begin
    if (!rst && btn_valid) begin
      if (q.size() == 0) begin
        check_val("unexpected_req", 1, 0);
      end else begin
        check_val("btn_xpos", btn_xpos, q[0].x);
        check_val("btn_ypos", btn_ypos, q[0].y);
        check_val("btn_col",  btn_col,  q[0].col);
        check_val("btn_row",  btn_row,  q[0].row);
        check_val("btn_size", btn_size, q[0].size);
        if (btn_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; btn_ready = 1'b0;
    cfg_xpos = '0; cfg_ypos = '0; cfg_size = '0; cfg_gap = '0; cfg_cols = '0; cfg_rows = '0;
    tick(); tick();
    check_val("rst_valid", btn_valid, 0);
    check_val("rst_xpos", btn_xpos, 0);
    check_val("rst_ypos", btn_ypos, 0);
    check_val("rst_size", btn_size, 0);
    check_val("rst_col", btn_col, 0);
    check_val("rst_row", btn_row, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", frame_done, 0);
    rst = 1'b0;
    tick();

    // 3x2 board, ready always high
    push_frame(100, 50, 20, 2, 3, 2);
    start_frame(100, 50, 20, 2, 3, 2);
    check_val("first_valid", btn_valid, 1);
    check_val("first_busy", busy, 1);
    run_frame(0, 7, 7);

    // Same board with back-pressure
    push_frame(100, 50, 20, 2, 3, 2);
    start_frame(100, 50, 20, 2, 3, 2);
    run_frame(1, -1, -1);

    // Empty board: no requests
    start_frame(10, 10, 8, 1, 0, 4);
    check_val("empty_valid", btn_valid, 0);
    check_val("empty_busy", busy, 1);
    run_frame(0, 1, 1);

    // Stray start mid-frame with altered cfg is ignored
    push_frame(100, 50, 20, 2, 3, 2);
    start_frame(100, 50, 20, 2, 3, 2);
    run_frame(2, 7, 7);

    // Reset after the third accept
    push_frame(100, 50, 20, 2, 3, 2);
    start_frame(100, 50, 20, 2, 3, 2);
    btn_ready = 1'b1;
    tick(); tick(); tick();
    check_val("pre_rst_col", btn_col, 0);
    check_val("pre_rst_row", btn_row, 1);
    rst = 1'b1;
    btn_ready = 1'b0;
    tick();
    check_val("abort_valid", btn_valid, 0);
    check_val("abort_xpos", btn_xpos, 0);
    check_val("abort_ypos", btn_ypos, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_done", frame_done, 0);
    q.delete();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("abort_no_done", frame_done, 0);
    end
    push_frame(100, 50, 20, 2, 3, 2);
    start_frame(100, 50, 20, 2, 3, 2);
    check_val("restart_col", btn_col, 0);
    check_val("restart_row", btn_row, 0);
    run_frame(0, 7, 7);

    // Coordinate wrap-around modulo 2^COORD_W
    push_frame(2040, 2030, 20, 2, 3, 2);
    start_frame(2040, 2030, 20, 2, 3, 2);
    run_frame(3, -1, -1);

    // Zero rows
    start_frame(5, 5, 4, 0, 3, 0);
    run_frame(0, 1, 1);

    // Single button
    push_frame(7, 9, 1, 0, 1, 1);
    start_frame(7, 9, 1, 0, 1, 1);
    run_frame(0, 2, 2);

    // Non-square board, largest size and gap, random back-pressure
    push_frame(300, 200, 127, 15, 4, 3);
    start_frame(300, 200, 127, 15, 4, 3);
    run_frame(3, -1, -1);

    // Single column, several rows
    push_frame(0, 0, 10, 3, 1, 5);
    start_frame(0, 0, 10, 3, 1, 5);
    run_frame(0, 6, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
